// File: rtl/bp_me_pkg.sv
// Shared stream/host bridge definitions: FSM state encoding and command frame layout.
package bp_me_pkg;

  typedef enum logic [2:0] {
    e_addr  = 3'd0,
    e_data  = 3'd1,
    e_issue = 3'd2,
    e_wait  = 3'd3,
    e_resp  = 3'd4
  } bp_stream_state_e;

  // The write flag occupies the top bit of the address word.
  function automatic int wr_flag_pos(input int stream_width);
    return stream_width - 1;
  endfunction

endpackage

// File: rtl/bsg_parallel_in_serial_out.sv
// Loads one wide word and shifts it out width_p bits at a time, least-significant slice first.
module bsg_parallel_in_serial_out #(
  parameter int width_p = 32,
  parameter int els_p   = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       load_i,
  input  logic [width_p*els_p-1:0]   data_i,
  input  logic                       yumi_i,
  output logic                       valid_o,
  output logic [width_p-1:0]         data_o,
  output logic                       last_o
);

  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic [width_p*els_p-1:0] data_r;
  logic [cnt_w_lp-1:0]      cnt_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      data_r <= '0;
      cnt_r  <= '0;
    end else if (load_i) begin
      data_r <= data_i;
      cnt_r  <= cnt_w_lp'(els_p);
    end else if (yumi_i && valid_o) begin
      data_r <= data_r >> width_p;
      cnt_r  <= cnt_r - cnt_w_lp'(1);
    end
  end

  assign valid_o = (cnt_r != '0);
  assign last_o  = (cnt_r == cnt_w_lp'(1));
  assign data_o  = data_r[width_p-1:0];

endmodule

// File: rtl/bp_stream_host.sv
// Bridges a two-word command stream onto a host memory port and serializes read data back.
// Optional read timeout enabled by defining BP_STREAM_HOST_TIMEOUT_EN.
module bp_stream_host
  import bp_me_pkg::*;
#(
  parameter int stream_data_width_p = 32,
  parameter int data_width_p        = 64,
  parameter int timeout_cycles_p    = 1024
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic                             stream_v_i,
  input  logic [stream_data_width_p-1:0]   stream_data_i,
  output logic                             stream_yumi_o,
  output logic                             stream_v_o,
  output logic [stream_data_width_p-1:0]   stream_data_o,
  input  logic                             stream_ready_and_i,
  output logic                             mem_v_o,
  output logic                             mem_w_o,
  output logic [stream_data_width_p-2:0]   mem_addr_o,
  output logic [data_width_p-1:0]          mem_data_o,
  input  logic                             mem_ready_and_i,
  input  logic                             mem_rdata_v_i,
  input  logic [data_width_p-1:0]          mem_rdata_i,
  output logic                             timeout_o
);

  localparam int els_lp    = data_width_p / stream_data_width_p;
  localparam int wr_pos_lp = wr_flag_pos(stream_data_width_p);

  if ((data_width_p % stream_data_width_p) != 0 || timeout_cycles_p < 1) begin : g_bad_cfg
    $error("bp_stream_host: unsupported parameter combination");
  end

  bp_stream_state_e        state_r;
  logic                    in_cmd, rdata_take, timeout_hit, piso_load;
  logic                    piso_v, piso_last, piso_yumi;
  logic [data_width_p-1:0] piso_data;

  assign in_cmd        = (state_r == e_addr) || (state_r == e_data);
  assign stream_yumi_o = reset_n_i & in_cmd & stream_v_i;
  assign rdata_take    = (state_r == e_wait) && mem_rdata_v_i;
  assign piso_load     = rdata_take || timeout_hit;
  assign piso_data     = rdata_take ? mem_rdata_i : '1;
  assign piso_yumi     = (state_r == e_resp) && stream_ready_and_i;
  assign stream_v_o    = (state_r == e_resp) && piso_v;

`ifdef BP_STREAM_HOST_TIMEOUT_EN
  localparam int tw_lp = $clog2(timeout_cycles_p + 1);
  logic [tw_lp-1:0] timer_r;
  logic             timeout_r;

  // Rdata arriving in the same cycle as terminal count takes priority.
  assign timeout_hit = (state_r == e_wait) && !mem_rdata_v_i && (timer_r == '0);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      timer_r   <= '0;
      timeout_r <= 1'b0;
    end else begin
      if (state_r == e_issue)
        timer_r <= tw_lp'(timeout_cycles_p - 1);
      else if (state_r == e_wait && timer_r != '0)
        timer_r <= timer_r - tw_lp'(1);
      if (timeout_hit)
        timeout_r <= 1'b1;
    end
  end

  assign timeout_o = timeout_r;
`else
  assign timeout_hit = 1'b0;
  assign timeout_o   = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r    <= e_addr;
      mem_v_o    <= 1'b0;
      mem_w_o    <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
    end else begin
      case (state_r)
        e_addr: if (stream_v_i) begin
          mem_w_o    <= stream_data_i[wr_pos_lp];
          mem_addr_o <= stream_data_i[wr_pos_lp-1:0];
          state_r    <= e_data;
        end
        e_data: if (stream_v_i) begin
          mem_data_o <= data_width_p'(stream_data_i);
          mem_v_o    <= 1'b1;
          state_r    <= e_issue;
        end
        e_issue: if (mem_ready_and_i) begin
          mem_v_o <= 1'b0;
          state_r <= mem_w_o ? e_addr : e_wait;
        end
        e_wait: if (piso_load) state_r <= e_resp;
        e_resp: if (stream_ready_and_i && piso_last) state_r <= e_addr;
        default: state_r <= e_addr;
      endcase
    end
  end

  bsg_parallel_in_serial_out #(
    .width_p (stream_data_width_p),
    .els_p   (els_lp)
  ) piso (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .load_i    (piso_load),
    .data_i    (piso_data),
    .yumi_i    (piso_yumi),
    .valid_o   (piso_v),
    .data_o    (stream_data_o),
    .last_o    (piso_last)
  );

endmodule

// File: tb/tb_bp_stream_host.sv
// Directed plus randomized bench for bp_stream_host against a memory model and frame rules.
module tb_bp_stream_host;

  localparam int sw         = 32;
  localparam int dw         = 64;
  localparam int els        = dw / sw;
  localparam int timeout_lp = 8;

  logic            clk_i = 1'b0;
  logic            reset_n_i;
  logic            stream_v_i;
  logic [sw-1:0]   stream_data_i;
  logic            stream_yumi_o;
  logic            stream_v_o;
  logic [sw-1:0]   stream_data_o;
  logic            stream_ready_and_i;
  logic            mem_v_o;
  logic            mem_w_o;
  logic [sw-2:0]   mem_addr_o;
  logic [dw-1:0]   mem_data_o;
  logic            mem_ready_and_i;
  logic            mem_rdata_v_i;
  logic [dw-1:0]   mem_rdata_i;
  logic            timeout_o;

  int n_checks = 0;
  int n_pass   = 0;

  logic [dw-1:0] mem_model [logic [sw-2:0]];
  logic [sw-2:0] ra;
  logic          rwr;
  logic [sw-1:0] rwd;
  logic [dw-1:0] rrd;

  always #5 clk_i = ~clk_i;

  bp_stream_host #(
    .stream_data_width_p (sw),
    .data_width_p        (dw),
    .timeout_cycles_p    (timeout_lp)
  ) dut (
    .clk_i              (clk_i),
    .reset_n_i          (reset_n_i),
    .stream_v_i         (stream_v_i),
    .stream_data_i      (stream_data_i),
    .stream_yumi_o      (stream_yumi_o),
    .stream_v_o         (stream_v_o),
    .stream_data_o      (stream_data_o),
    .stream_ready_and_i (stream_ready_and_i),
    .mem_v_o            (mem_v_o),
    .mem_w_o            (mem_w_o),
    .mem_addr_o         (mem_addr_o),
    .mem_data_o         (mem_data_o),
    .mem_ready_and_i    (mem_ready_and_i),
    .mem_rdata_v_i      (mem_rdata_v_i),
    .mem_rdata_i        (mem_rdata_i),
    .timeout_o          (timeout_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_yumi"}, stream_yumi_o, 0);
    check({tag, "_stream_v"}, stream_v_o, 0);
    check({tag, "_mem_v"}, mem_v_o, 0);
    check({tag, "_mem_w"}, mem_w_o, 0);
    check({tag, "_mem_addr"}, mem_addr_o, 0);
    check({tag, "_mem_data"}, mem_data_o, 0);
    check({tag, "_timeout"}, timeout_o, 0);
  endtask

  // One full command; inputs are driven on negedges, registered outputs checked there too.
  task automatic do_cmd(input logic wr, input logic [sw-2:0] addr, input logic [sw-1:0] wdata,
                        input logic [dw-1:0] rdata, input int mem_stall, input int rd_delay,
                        input bit bp3, input bit to_mode, input bit abort);
    int idx;
    int guard;
    logic [dw-1:0] exp_word;
    @(negedge clk_i);
    stream_v_i = 1'b1;
    stream_data_i = {wr, addr};
    #1 check("yumi_word0", stream_yumi_o, 1);
    @(negedge clk_i);
    stream_data_i = wdata;
    #1 check("yumi_word1", stream_yumi_o, 1);
    @(negedge clk_i);
    check("mem_v", mem_v_o, 1);
    check("mem_w", mem_w_o, wr);
    check("mem_addr", mem_addr_o, addr);
    check("mem_data", mem_data_o, {32'h0, wdata});
    check("stream_v_issue", stream_v_o, 0);
    stream_data_i = $urandom;
    mem_rdata_v_i = (mem_stall > 0);
    mem_rdata_i = {$urandom, $urandom};
    #1 check("yumi_issue", stream_yumi_o, 0);
    for (int k = 0; k < mem_stall; k++) begin
      @(negedge clk_i);
      check("mem_v_hold", mem_v_o, 1);
      check("yumi_issue_hold", stream_yumi_o, 0);
    end
    mem_rdata_v_i = 1'b0;
    mem_ready_and_i = 1'b1;
    @(negedge clk_i);
    mem_ready_and_i = 1'b0;
    check("mem_v_done", mem_v_o, 0);
    check("stream_v_idle", stream_v_o, 0);
    if (wr) begin
      stream_v_i = 1'b0;
      check("timeout_flag_wr", timeout_o, 0);
      return;
    end
    #1 check("yumi_wait", stream_yumi_o, 0);
    if (to_mode) begin
      for (int k = 1; k < timeout_lp; k++) begin
        @(negedge clk_i);
        check("wait_quiet", stream_v_o, 0);
      end
    end else begin
      for (int k = 0; k < rd_delay; k++) begin
        @(negedge clk_i);
        check("wait_quiet", stream_v_o, 0);
        check("yumi_wait_hold", stream_yumi_o, 0);
      end
      mem_rdata_v_i = 1'b1;
      mem_rdata_i = rdata;
    end
    @(negedge clk_i);
    mem_rdata_v_i = 1'b0;
    mem_rdata_i = {$urandom, $urandom};
    idx = 0;
    guard = 0;
    while (idx < els && guard < 40) begin
      if (abort && idx == 1) break;
      exp_word = to_mode ? {dw{1'b1}} : (rdata >> (sw * idx));
      check("resp_v", stream_v_o, 1);
      check("resp_word", stream_data_o, exp_word[sw-1:0]);
      check("yumi_resp", stream_yumi_o, 0);
      mem_rdata_v_i = to_mode && (guard == 1);
      stream_ready_and_i = bp3 ? (guard >= 3) : ($urandom_range(0, 2) != 0);
      if (stream_ready_and_i) idx++;
      guard++;
      @(negedge clk_i);
    end
    mem_rdata_v_i = 1'b0;
    stream_v_i = 1'b0;
    stream_ready_and_i = 1'b0;
    if (abort) return;
    check("resp_complete", idx, els);
    check("stream_v_after", stream_v_o, 0);
    check("timeout_flag", timeout_o, to_mode);
  endtask

  initial begin
    reset_n_i = 1'b0;
    stream_v_i = 1'b1;
    stream_data_i = 32'h8000_0001;
    stream_ready_and_i = 1'b0;
    mem_ready_and_i = 1'b0;
    mem_rdata_v_i = 1'b1;
    mem_rdata_i = '0;
    @(negedge clk_i);
    check_reset_outputs("por");
    stream_v_i = 1'b0;
    mem_rdata_v_i = 1'b0;
    @(negedge clk_i);
    reset_n_i = 1'b1;

    // Directed write, read, and backpressured read.
    do_cmd(1'b1, 31'h1000, 32'h1234_5678, '0, 1, 0, 1'b0, 1'b0, 1'b0);
    do_cmd(1'b0, 31'h2000, 32'h0, 64'hCAFE_F00D_DEAD_BEEF, 0, 5, 1'b0, 1'b0, 1'b0);
    do_cmd(1'b0, 31'h2000, 32'h0, 64'h0123_4567_89AB_CDEF, 2, 1, 1'b1, 1'b0, 1'b0);

    // Reset between word0 and word1 drops the partial frame.
    @(negedge clk_i);
    stream_v_i = 1'b1;
    stream_data_i = 32'h8000_0ABC;
    @(negedge clk_i);
    stream_v_i = 1'b1;
    reset_n_i = 1'b0;
    #1 check_reset_outputs("midframe");
    @(negedge clk_i);
    stream_v_i = 1'b0;
    reset_n_i = 1'b1;
    @(negedge clk_i);
    check("post_reset_mem_v", mem_v_o, 0);
    do_cmd(1'b1, 31'h4, 32'h1, '0, 0, 0, 1'b0, 1'b0, 1'b0);

    // Reset after the first response word: the second word must never appear.
    do_cmd(1'b0, 31'h30, 32'h0, 64'h1111_2222_3333_4444, 0, 2, 1'b0, 1'b0, 1'b1);
    reset_n_i = 1'b0;
    #1 check_reset_outputs("midresp");
    @(negedge clk_i);
    reset_n_i = 1'b1;
    stream_ready_and_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      check("midresp_quiet", stream_v_o, 0);
    end
    stream_ready_and_i = 1'b0;

    for (int n = 0; n < 24; n++) begin
      ra  = 31'($urandom_range(0, 7) * 16);
      rwr = 1'($urandom_range(0, 1));
      rwd = $urandom;
      if (!mem_model.exists(ra)) mem_model[ra] = {$urandom, $urandom};
      rrd = mem_model[ra];
      do_cmd(rwr, ra, rwd, rrd, $urandom_range(0, 3), $urandom_range(0, 6), 1'b0, 1'b0, 1'b0);
      if (rwr) mem_model[ra] = {32'h0, rwd};
    end

`ifdef BP_STREAM_HOST_TIMEOUT_EN
    do_cmd(1'b0, 31'h40, 32'h0, '0, 0, 0, 1'b0, 1'b1, 1'b0);
    check("timeout_sticky", timeout_o, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bp_stream_host.md
BP_STREAM_HOST -- requirements
Module: bp_stream_host

Interface
REQ-001 The block SHALL have parameter stream_data_width_p, default 32: stream word width; the MSB of the address word is the write flag.
REQ-002 The block SHALL have parameter data_width_p, default 64: host data width; it SHALL be a multiple of stream_data_width_p.
REQ-003 The block SHALL have parameter timeout_cycles_p, default 1024: read-wait limit, used only under the macro.
REQ-004 clk_i  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset_n_i  in  1  asynchronous, active-low reset.
REQ-006 stream_v_i / stream_data_i / stream_yumi_o  in/in/out  1/stream_data_width_p/1  inbound command words, valid-yumi.
REQ-007 stream_v_o / stream_data_o / stream_ready_and_i  out/out/in  1/stream_data_width_p/1  outbound response words, valid-ready.
REQ-008 mem_v_o / mem_w_o / mem_addr_o / mem_data_o / mem_ready_and_i  out/out/out/out/in  1/1/stream_data_width_p-1/data_width_p/1  host access, valid-ready.
REQ-009 mem_rdata_v_i / mem_rdata_i  in/in  1/data_width_p  read return; exactly one per accepted read; no backpressure.
REQ-010 timeout_o  out  1  sticky flag: a read timed out.

Function
REQ-011 The command frame SHALL be two words: word0 = {wr, addr[stream_data_width_p-2:0]}, then word1 = write data (present for reads too, discarded).
REQ-012 The FSM SHALL have states e_addr, e_data, e_issue, e_wait, e_resp; reset state is e_addr.
REQ-013 In e_addr and e_data, stream_yumi_o SHALL equal stream_v_i; on yumi, word0 is latched and the FSM goes to e_data, or word1 is latched and the FSM goes to e_issue; in all other states stream_yumi_o is 0.
REQ-014 In e_issue, mem_v_o SHALL be 1 and driven from registers; word1 is zero-extended to data_width_p on mem_data_o.
REQ-015 On mem_ready_and_i in e_issue, a write SHALL return to e_addr and produce no stream response; a read SHALL go to e_wait.
REQ-016 Minimum latency: word0 yumi in cycle N, word1 in N+1, mem_v_o in N+2.
REQ-017 In e_wait, mem_rdata_v_i SHALL load the bsg_parallel_in_serial_out and move the FSM to e_resp; mem_rdata_v_i in any other state SHALL be ignored.
REQ-018 In e_resp, the block SHALL emit data_width_p/stream_data_width_p words, least-significant first, one per stream_ready_and_i handshake; stream_data_o is held stable while stream_v_o=1 and not ready.
REQ-019 After the last word handshakes, the FSM SHALL return to e_addr; with ready held high, a 64-bit read response occupies 2 consecutive cycles.
REQ-020 No new command word SHALL be accepted until the current command completes; there is no overlap.

Reset
REQ-021 Assertion of reset_n_i SHALL immediately force: state e_addr, stream_yumi_o=0, stream_v_o=0, mem_v_o=0, mem_w_o=0, mem_addr_o=0, mem_data_o=0, timeout_o=0, serializer empty, timeout counter 0.
REQ-022 A reset mid-frame or mid-response SHALL discard the partial command or response, and no word of it SHALL be emitted after deassertion.

Configuration
REQ-023 With macro BP_STREAM_HOST_TIMEOUT_EN defined, a counter SHALL run in e_wait; after timeout_cycles_p cycles without mem_rdata_v_i, the block SHALL load an all-ones response, set timeout_o, and go to e_resp; a late mem_rdata_v_i is ignored.
REQ-024 Without BP_STREAM_HOST_TIMEOUT_EN, the block SHALL have no counter, SHALL wait in e_wait indefinitely, and SHALL tie timeout_o to 0.

Structure
REQ-025 The FSM state enum and the write-flag bit position constant SHALL live in bp_me_pkg, shared with the initiator side.
REQ-026 Response serialization SHALL use one sub-module instance, bsg_parallel_in_serial_out (width stream_data_width_p, els data_width_p/stream_data_width_p).

Verification
REQ-027 Write: words 0x8000_1000, 0x1234_5678 -> one mem_v_o with w=1, addr=0x1000, data=0x0000_0000_1234_5678; no stream_v_o.
REQ-028 Read: words 0x0000_2000, 0x0, then rdata 0xCAFE_F00D_DEAD_BEEF 5 cycles later -> stream words 0xDEAD_BEEF then 0xCAFE_F00D.
REQ-029 Backpressure: stream_ready_and_i low for 3 cycles during the read response -> word stable, no loss, no duplicate; stream_yumi_o stays 0 throughout.
REQ-030 Timeout (macro on, timeout_cycles_p=8): read with no rdata -> after 8 cycles, words 0xFFFF_FFFF x2 and timeout_o=1; rdata arriving at cycle 10 is ignored.
REQ-031 Reset between word0 and word1 -> after release, the next frame 0x8000_0004, 0x1 issues a write to addr 0x4 only.
